// File: rtl/braille_pkg.sv
// Shared types and helpers for the braille cell driver and its timer.
package braille_pkg;

    localparam int DOT_COUNT = 8;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        PULSE,
        GAP,
        HOLD,
        DONE
    } state_t;

    // Actuator select for a single dot index.
    function automatic logic [DOT_COUNT-1:0] onehot8(input logic [2:0] idx);
        logic [DOT_COUNT-1:0] one;
        one = {{(DOT_COUNT-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/braille_cell_driver_if.sv
// Pattern handshake and actuator-side signals of the braille cell driver.
interface braille_cell_driver_if;
    import braille_pkg::*;

    logic [DOT_COUNT-1:0] pattern_in;
    logic                 pattern_valid;
    logic                 ready;
    logic                 abort;
    logic [DOT_COUNT-1:0] dot_drive;
    logic [DOT_COUNT-1:0] cell_out;
    logic                 busy;
    logic                 done;
    logic                 next_req;

    // Upstream side: the converter supplying patterns and the cancel line.
    modport master (
        output pattern_in, pattern_valid, abort,
        input  ready, dot_drive, cell_out, busy, done, next_req
    );

    // Driver side.
    modport slave (
        input  pattern_in, pattern_valid, abort,
        output ready, dot_drive, cell_out, busy, done, next_req
    );
endinterface

// File: rtl/braille_pulse_timer.sv
// Loadable down-counter with a zero flag, shared by every timed state of the
// cell driver. A state lasting N cycles loads N-1 and leaves when zero is set.
module braille_pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; otherwise count down while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

    // Decrementing past zero would wrap and stretch a pulse indefinitely.
    no_underflow: assert property (@(posedge clk) disable iff (reset)
        (en && !load) |-> (cnt != '0));

endmodule

// File: rtl/braille_cell_driver.sv
// Fires a braille cell one dot at a time (pulse, gap), then presents the full
// pattern for a hold window, pulses done/next_req and returns to idle.
module braille_cell_driver
    import braille_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int HOLD_CYCLES  = 8,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    braille_cell_driver_if.slave bus
);

    localparam int               IDX_W    = $clog2(DOT_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DOT_COUNT - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

    state_t               state;
    logic [DOT_COUNT-1:0] pat;
    logic [IDX_W-1:0]     idx;
    logic [DOT_COUNT-1:0] dot_drive;
    logic [DOT_COUNT-1:0] cell_out;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic                 next_req;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_en;
    logic                 tmr_zero;
    logic                 cur_bit;
    logic                 last_dot;

    assign cur_bit  = pat[idx];
    assign last_dot = (idx == LAST_IDX);
    abort_live: assert property (@(posedge clk) disable iff (reset) $onehot0(dot_drive));

    braille_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // Timer control: load on entry to PULSE/GAP/HOLD, count while inside them.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        if (bus.abort && state != IDLE) begin
            tmr_load = 1'b1;
        end else begin
            case (state)
                SCAN: begin
                    if (cur_bit) begin
                        tmr_load = 1'b1;
                        tmr_val  = PULSE_LD;
                    end else if (last_dot) begin
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end
                end
                PULSE: begin
                    if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                    end else if (last_dot) begin
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end
                end
                GAP: begin
                    if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else if (last_dot) begin
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end
                end
                HOLD: begin
                    tmr_en = !tmr_zero;
                end
                default: ;
            endcase
        end
    end

    // Cell sequencer with registered outputs; abort overrides every transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pat       <= '0;
            idx       <= '0;
            dot_drive <= '0;
            cell_out  <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            next_req  <= 1'b0;
        end else begin
            done     <= 1'b0;
            next_req <= 1'b0;
            if (bus.abort && state != IDLE) begin
                state     <= IDLE;
                idx       <= '0;
                dot_drive <= '0;
                cell_out  <= '0;
                ready     <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.pattern_valid) begin
                            pat   <= bus.pattern_in;
                            idx   <= '0;
                            state <= SCAN;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (cur_bit) begin
                            state     <= PULSE;
                            dot_drive <= onehot8(idx);
                        end else if (last_dot) begin
                            state    <= HOLD;
                            cell_out <= pat;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    PULSE: begin
                        if (tmr_zero) begin
                            dot_drive <= '0;
                            if (GAP_CYCLES > 0) begin
                                state <= GAP;
                            end else if (last_dot) begin
                                state    <= HOLD;
                                cell_out <= pat;
                            end else begin
                                state <= SCAN;
                                idx   <= idx + IDX_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (tmr_zero) begin
                            if (last_dot) begin
                                state    <= HOLD;
                                cell_out <= pat;
                            end else begin
                                state <= SCAN;
                                idx   <= idx + IDX_W'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (tmr_zero) begin
                            state    <= DONE;
                            cell_out <= '0;
                            done     <= 1'b1;
                            next_req <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ready     = ready;
    assign bus.busy      = busy;
    assign bus.dot_drive = dot_drive;
    assign bus.cell_out  = cell_out;
    assign bus.done      = done;
    assign bus.next_req  = next_req;

endmodule

// File: tb/tb_braille_cell_driver.sv
// Scoreboard bench for braille_cell_driver: stimulus pushes the expected cell
// timeline per accepted pattern, a negedge monitor checks every cycle.
module tb_braille_cell_driver;

    localparam int P = 4;
    localparam int G = 2;
    localparam int H = 8;

    logic clk = 1'b0;
    logic reset;

    braille_cell_driver_if bus ();

    braille_cell_driver #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .HOLD_CYCLES  (H),
        .CNT_W        (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      pat;
        logic [15:0]     done_cyc;
        logic [15:0]     hold_start;
        logic [7:0][7:0] ps;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_done_lat;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Walk the dots: 1 scan cycle each, plus pulse+gap after a set dot.
    function automatic exp_t model(input logic [7:0] p);
        exp_t e;
        int   t;
        t = 1;
        e = '0;
        e.pat = p;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) begin
                e.ps[i] = 8'(t + 1);
                t += 1 + P + G;
            end else begin
                t += 1;
            end
        end
        e.hold_start = 16'(t);
        e.done_cyc   = 16'(8 + $countones(p) * (P + G) + H + 1);
        return e;
    endfunction

    function automatic logic [7:0] exp_dot(input exp_t e, input int c);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            if (e.pat[i] && c >= int'(e.ps[i]) && c < int'(e.ps[i]) + P) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] exp_cell(input exp_t e, input int c);
        if (c >= int'(e.hold_start) && c < int'(e.hold_start) + H) return e.pat;
        return 8'h00;
    endfunction

    // Monitor: pops the expectation at the accepting edge, checks each cycle.
    exp_t cur;
    bit   in_tx = 1'b0;
    int   c = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_tx = 1'b0;
            end else begin
                chk("dot_onehot0", 32'($onehot0(bus.dot_drive)), 1);
                if (in_tx) begin
                    c++;
                    chk($sformatf("dot_drive c=%0d", c), bus.dot_drive, exp_dot(cur, c));
                    chk($sformatf("cell_out c=%0d", c), bus.cell_out, exp_cell(cur, c));
                    chk($sformatf("done c=%0d", c), bus.done, 32'(c == int'(cur.done_cyc)));
                    chk($sformatf("next_req c=%0d", c), bus.next_req, 32'(c == int'(cur.done_cyc)));
                    chk($sformatf("busy c=%0d", c), bus.busy, 1);
                    chk($sformatf("ready c=%0d", c), bus.ready, 0);
                    if (bus.done) last_done_lat = c;
                    if (c >= int'(cur.done_cyc) || bus.abort) in_tx = 1'b0;
                end else begin
                    chk("idle_dot", bus.dot_drive, 0);
                    chk("idle_cell", bus.cell_out, 0);
                    chk("idle_done", bus.done, 0);
                    chk("idle_next_req", bus.next_req, 0);
                    chk("idle_busy", bus.busy, 0);
                    chk("idle_ready", bus.ready, 1);
                    if (bus.pattern_valid && bus.ready) begin
                        chk("expect_pending", 32'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            cur   = exp_q.pop_front();
                            in_tx = 1'b1;
                            c     = 0;
                        end
                    end
                end
            end
        end
    end

    // Called at edge+1; leaves the bench in cycle 1 of the new cell.
    task automatic start(input logic [7:0] p, input bit with_abort);
        int n;
        n = 0;
        while (!bus.ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_start", bus.ready, 1);
        last_done_lat = -1;
        exp_q.push_back(model(p));
        bus.pattern_in    = p;
        bus.pattern_valid = 1'b1;
        bus.abort         = with_abort;
        @(posedge clk);
        #1;
        bus.pattern_valid = 1'b0;
        bus.abort         = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_return", bus.ready, 1);
    endtask

    task automatic junk_valid(input int cycles);
        bus.pattern_in    = 8'h3F;
        bus.pattern_valid = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        bus.pattern_valid = 1'b0;
    endtask

    task automatic abort_at(input int a);
        repeat (a - 1) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
    endtask

    initial begin
        logic [7:0] p;
        int         mode;
        int         dc;

        bus.pattern_in    = '0;
        bus.pattern_valid = 1'b0;
        bus.abort         = 1'b0;
        reset             = 1'b1;
        last_done_lat     = -1;
        #12;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dot", bus.dot_drive, 0);
        chk("rst_cell", bus.cell_out, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_next_req", bus.next_req, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        start(8'h00, 1'b0);
        wait_idle();
        chk("latency_00", last_done_lat, 17);

        start(8'h01, 1'b0);
        wait_idle();
        chk("latency_01", last_done_lat, 23);

        start(8'hFF, 1'b0);
        wait_idle();
        chk("latency_ff", last_done_lat, 65);

        start(8'h24, 1'b0);
        junk_valid(10);
        wait_idle();
        chk("latency_24", last_done_lat, 29);

        // Abort in the second pulse of 0xFF (cycles 9-12), then restart at once.
        start(8'hFF, 1'b0);
        abort_at(10);
        chk("abort_ready", bus.ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_dot", bus.dot_drive, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_next_req", bus.next_req, 0);
        start(8'h81, 1'b0);
        wait_idle();
        chk("latency_after_abort", last_done_lat, 8 + 2 * (P + G) + H + 1);

        // Asynchronous reset in the hold window of 0x3C (cycles 33-40).
        start(8'h3C, 1'b0);
        repeat (34) @(posedge clk);
        #1;
        chk("hold_3c", bus.cell_out, 8'h3C);
        #1;
        reset = 1'b1;
        #1;
        chk("async_cell", bus.cell_out, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_ready", bus.ready, 1);
        chk("async_dot", bus.dot_drive, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        p = 8'h5A;
        start(p, 1'b0);
        wait_idle();
        chk("latency_after_reset", last_done_lat, 8 + $countones(p) * (P + G) + H + 1);

        for (int it = 0; it < 16; it++) begin
            p    = 8'($urandom);
            mode = $urandom_range(0, 3);
            dc   = 8 + $countones(p) * (P + G) + H + 1;
            start(p, mode == 1);
            if (mode == 2) junk_valid($urandom_range(1, 12));
            else if (mode == 3) abort_at($urandom_range(1, dc - 1));
            wait_idle();
            if (mode != 3) chk($sformatf("latency_rand_%0d", it), last_done_lat, dc);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/braille_cell_driver.md
Name: braille_cell_driver

Overview:
- Downstream stage of the braille converter. It consumes each 8-bit braille dot pattern the converter produces and fires the cell's actuators one dot at a time, which keeps peak solenoid current low.
- It then holds the cell raised, reports completion, and requests the next character.
- It sits between the converter's pattern output and the actuator pads.

Parameters:
- PULSE_CYCLES, 4, cycles each set dot's actuator is driven; must be >= 1.
- GAP_CYCLES, 2, idle cycles after each pulse before scanning resumes; 0 allowed.
- HOLD_CYCLES, 8, cycles the full pattern is presented on cell_out after firing; must be >= 1.
- CNT_W, 16, width of the shared timing counter; must hold max(PULSE_CYCLES, GAP_CYCLES, HOLD_CYCLES).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pattern_in  input  8  dot pattern; bit i = dot i+1
- pattern_valid  input  1  pattern_in valid this cycle
- ready  output  1  block can accept a pattern
- abort  input  1  synchronous cancel of the current cell
- dot_drive  output  8  one-hot (or zero) actuator pulse
- cell_out  output  8  latched pattern, valid in HOLD only
- busy  output  1  high in any state other than IDLE
- done  output  1  single-cycle completion pulse
- next_req  output  1  single-cycle request for the next character; coincident with done

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, dot_drive=0, cell_out=0, busy=0, done=0, next_req=0, latched pattern=0, idx=0, counter=0.
- States: IDLE, SCAN, PULSE, GAP, HOLD, DONE.
- IDLE:
  - ready=1.
  - When pattern_valid=1 on a clock edge, latch pattern_in, set idx=0, go to SCAN.
  - pattern_valid while not ready is ignored and never buffered.
- SCAN:
  - Examine latched bit idx.
  - Bit set: go to PULSE and load the counter.
  - Bit clear: if idx=7 go to HOLD, else idx+1 and stay in SCAN.
  - A clear bit costs exactly 1 cycle.
- PULSE:
  - dot_drive = one-hot(idx) for exactly PULSE_CYCLES cycles.
  - Then go to GAP, or to the post-GAP transition directly if GAP_CYCLES=0.
- GAP:
  - dot_drive=0 for GAP_CYCLES cycles.
  - Then, if idx=7, go to HOLD; otherwise idx+1 and go to SCAN.
- dot_drive is never more than one-hot. It is zero in every state except PULSE.
- HOLD: cell_out = latched pattern for HOLD_CYCLES cycles; cell_out=0 outside HOLD.
- DONE:
  - One cycle; done=1 and next_req=1.
  - Then IDLE, with ready=1 on the following cycle.
- Latency, from the accepting edge (cycle 0) with k set bits:
  - done is high in cycle 8 + k*(PULSE_CYCLES+GAP_CYCLES) + HOLD_CYCLES + 1.
  - ready is high in the next cycle.
- abort:
  - abort=1 in any non-IDLE state sends the block to IDLE on the next edge.
  - dot_drive and cell_out go to 0 on that edge; done and next_req are not asserted.
  - abort in IDLE has no effect.
  - abort has priority over every other transition.
- Reset mid-operation: outputs return to reset values immediately (asynchronously). No residual pulse is allowed.
- Counter: it is loaded with N-1 on entry to a timed state and decrements to 0; the exit happens on the cycle the count is 0. Counter underflow and wrap are illegal and must be covered by an assertion.
- Pattern 0x00 still walks all 8 SCAN cycles, so latency is deterministic.

Decomposition:
- Shared package braille_pkg:
  - state enum (IDLE, SCAN, PULSE, GAP, HOLD, DONE);
  - DOT_COUNT=8;
  - function onehot8(idx).
- Sub-module: braille_pulse_timer, a loadable down-counter with a zero flag (CNT_W wide), instantiated once and shared by PULSE, GAP and HOLD.
- The FSM and the idx register stay in braille_cell_driver.

Test Plan (defaults PULSE=4, GAP=2, HOLD=8):
- Reset released, pattern 0x00 accepted at cycle 0 -> dot_drive stays 0; cell_out=0x00 in cycles 9-16; done and next_req high in cycle 17; ready=1 in cycle 18.
- Pattern 0x01 -> dot_drive=0x01 in cycles 2-5, 0 in cycles 6-7; cell_out=0x01 in cycles 15-22; done in cycle 23.
- Pattern 0xFF -> eight one-hot pulses 0x01, 0x02 … 0x80, each 4 cycles with 2-cycle gaps; done in cycle 65; dot_drive popcount never exceeds 1.
- Pattern 0x24 with pattern_valid re-asserted (0x3F) while busy -> the second pattern is ignored; pulses occur only on 0x04 then 0x20; done in cycle 29.
- abort asserted during the second PULSE of 0xFF -> next cycle: IDLE, dot_drive=0, no done/next_req; a new pattern is accepted immediately afterwards.
- Async reset asserted mid-HOLD of 0x3C -> cell_out, busy and ready take reset values without waiting for a clock edge; after release, the next accepted pattern follows the exact latency formula.
